fm_iq_capture: RTL and testbench
================================

Name: fm_iq_capture

Overview:
- Front-end stage between the ADC sampling macro and the FM demodulation, RSSI scan and IQ dump consumers.
- Receives the alternating CH6 (I) / CH4 (Q) ADC conversions, brings the EOC strobe into the system clock domain, and pairs the conversions into signed I/Q samples.
- Optionally removes DC offset, buffers the pairs in a small FIFO, and hands them downstream with a valid/ready handshake and overflow accounting.

Parameters:
- ADC_W, 12, ADC sample width, unsigned offset-binary.
- FIFO_DEPTH, 4, I/Q pair FIFO entries. Power of two, ≥2.
- DC_SHIFT, 10, DC tracker time constant as a power of two (used only with FM_IQ_DCBLOCK_EN).
- CH_I, 3'b110, ADC channel code carrying I.
- CH_Q, 3'b100, ADC channel code carrying Q.

Ports:
- clk  in  1  system clock. Single clock domain.
- RSTn  in  1  asynchronous active-low reset.
- enable  in  1  1 = capture on; 0 = flush, idle.
- eoc  in  1  ADC end-of-conversion. Asynchronous to clk.
- adc_data  in  ADC_W  ADC result. Held stable from eoc rise until the next conversion.
- channel  in  3  channel code of the conversion that produced adc_data.
- iq_ready  in  1  downstream accepts a pair.
- clear  in  1  one-cycle pulse; clears sticky flag and counters.
- iq_valid  out  1  FIFO head holds a valid pair.
- i_data  out  ADC_W  signed two's-complement I.
- q_data  out  ADC_W  signed two's-complement Q.
- overflow  out  1  sticky: a pair was dropped because the FIFO was full.
- drop_cnt  out  8  saturating count of pairs dropped on FIFO full.
- pair_err_cnt  out  8  saturating count of orphan or duplicate samples.

Behaviour:
- Reset values: iq_valid=0, i_data=0, q_data=0, overflow=0, drop_cnt=0, pair_err_cnt=0. FIFO empty, no pending I, DC accumulators 0, synchronizer flops 0.
- EOC sync: two-flop synchronizer, then a third flop for rise detect. rise = s2 & ~s3.
  - On a rise cycle, capture adc_data and channel. eoc glitches shorter than one clk need not be detected.
- Conversion: x = adc_data − 2^(ADC_W−1), kept at ADC_W+1 bits. Final result saturates to the signed ADC_W range [−2048, +2047].
- Pairing FSM, states WAIT_I and HAVE_I:
  - WAIT_I + CH_I sample: store I, go to HAVE_I.
  - WAIT_I + CH_Q sample: discard it, pair_err_cnt+1.
  - HAVE_I + CH_Q sample: form pair, push request, go to WAIT_I.
  - HAVE_I + CH_I sample: replace stored I, pair_err_cnt+1, stay in HAVE_I.
  - Any other channel code: ignored, no count.
- FIFO push is one clk after the pairing rise cycle.
  - Latency from the Q rise cycle to iq_valid=1 is 2 clk when the FIFO is empty and no pop is pending.
  - i_data/q_data show the FIFO head combinationally from registered storage. They are stable while iq_valid=1 and iq_ready=0.
- Pop occurs when iq_valid & iq_ready.
- Push while full with no same-cycle pop: pair dropped, overflow=1, drop_cnt+1, saturating at 255.
- Push while full with a same-cycle pop: push accepted, no drop.
- Push while empty with iq_ready=1: head appears next cycle. There is no bypass.
- clear: zeroes overflow, drop_cnt and pair_err_cnt in the next cycle. If a count event coincides with clear, clear wins and the event is lost.
- enable=0, effective the next cycle:
  - FIFO flushed, iq_valid=0, FSM forced to WAIT_I.
  - Rises ignored. Synchronizer keeps running.
  - DC accumulators and counters keep their values.
- enable 0→1: capture resumes with the first rise seen after the enable edge.
- Reset mid-operation: all state returns to reset values immediately, because the reset is asynchronous.

Optional Feature:
- Macro FM_IQ_DCBLOCK_EN.
- Defined: per-channel accumulator acc, width ADC_W+1+DC_SHIFT, signed.
  - est = acc >>> DC_SHIFT.
  - Output y = sat(x − est).
  - On each accepted sample of that channel: acc ← acc + x − est.
  - The accumulator update happens even when the FIFO is full. Orphan Q samples do not update it.
- Undefined: y = x. No accumulators are built.

Test Plan:
- Reset, then I=0xA00, Q=0x600 (DC block off) → one pair, i_data=+512, q_data=−512, iq_valid 2 clk after the Q rise cycle.
- iq_ready=0; 5 consecutive pairs with FIFO_DEPTH=4 → 4 held, overflow=1, drop_cnt=1. Pulse clear → overflow=0, drop_cnt=0.
- Sequence Q, I, I, Q → pair_err_cnt=2; one pair emitted using the second I.
- Full FIFO with iq_ready=1 on the push cycle → no drop, occupancy stays 4.
- FM_IQ_DCBLOCK_EN, DC_SHIFT=4, constant I=Q=0x900 (x=+256) for 200 pairs → outputs decay to |y|≤1.
- Drop enable with 2 pairs queued → iq_valid=0 next cycle. Re-enable, then I, Q → exactly one new pair. Assert RSTn low mid-burst → all outputs 0 asynchronously.

Source files
------------

// File: rtl/fm_iq_capture.sv
// fm_iq_capture: ADC I/Q front end.
// Synchronizes the ADC end-of-conversion strobe and pairs CH_I/CH_Q conversions
// into signed I/Q samples. The pairs go through a small FIFO to a valid/ready
// consumer, with drop and pairing-error accounting.
// Optional DC removal is enabled by defining the macro FM_IQ_DCBLOCK_EN.
module fm_iq_capture #(
    parameter int          ADC_W      = 12,
    parameter int          FIFO_DEPTH = 4,
    parameter int          DC_SHIFT   = 10,
    parameter logic [2:0]  CH_I       = 3'b110,
    parameter logic [2:0]  CH_Q       = 3'b100
) (
    input  logic             clk,
    input  logic             RSTn,
    input  logic             enable,
    input  logic             eoc,
    input  logic [ADC_W-1:0] adc_data,
    input  logic [2:0]       channel,
    input  logic             iq_ready,
    input  logic             clear,
    output logic             iq_valid,
    output logic [ADC_W-1:0] i_data,
    output logic [ADC_W-1:0] q_data,
    output logic             overflow,
    output logic [7:0]       drop_cnt,
    output logic [7:0]       pair_err_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {WAIT_I = 1'b0, HAVE_I = 1'b1} pair_state_t;

    // Clamp a widened signed difference into the signed ADC_W range.
    function automatic logic [ADC_W-1:0] sat_fn(input logic signed [ADC_W+1:0] v);
        logic signed [ADC_W+1:0] maxv;
        logic signed [ADC_W+1:0] minv;
        maxv = {3'b000, {(ADC_W-1){1'b1}}};
        minv = {3'b111, {(ADC_W-1){1'b0}}};
        if (v > maxv) begin
            sat_fn = maxv[ADC_W-1:0];
        end else if (v < minv) begin
            sat_fn = minv[ADC_W-1:0];
        end else begin
            sat_fn = v[ADC_W-1:0];
        end
    endfunction

    logic                sync1_q, sync2_q, sync3_q;
    logic                rise_s;
    logic signed [ADC_W:0]   x_s;
    logic signed [ADC_W+1:0] diff_i_s, diff_q_s;
    pair_state_t         state_q, state_d;
    logic [ADC_W-1:0]    istore_q, istore_d;
    logic [ADC_W-1:0]    pair_i_q, pair_i_d, pair_q_q, pair_q_d;
    logic                push_req_q, push_req_d;
    logic                err_evt_s;
    logic [ADC_W-1:0]    fifo_i_q [FIFO_DEPTH];
    logic [ADC_W-1:0]    fifo_q_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                full_s, pop_s, push_ok_s, drop_s;
    logic                overflow_q;
    logic [7:0]          drop_cnt_q, pair_err_cnt_q;

    // Offset-binary to two's complement: flipping the MSB subtracts mid-scale.
    assign x_s    = {~adc_data[ADC_W-1], ~adc_data[ADC_W-1], adc_data[ADC_W-2:0]};
    assign rise_s = sync2_q & ~sync3_q;

`ifdef FM_IQ_DCBLOCK_EN
    localparam int ACC_W = ADC_W + 1 + DC_SHIFT;
    logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic signed [ADC_W:0]   est_i_s, est_q_s;

    // The top bits of the accumulator are its arithmetic shift by DC_SHIFT.
    assign est_i_s  = acc_i_q[ACC_W-1:DC_SHIFT];
    assign est_q_s  = acc_q_q[ACC_W-1:DC_SHIFT];
    assign diff_i_s = {x_s[ADC_W], x_s} - {est_i_s[ADC_W], est_i_s};
    assign diff_q_s = {x_s[ADC_W], x_s} - {est_q_s[ADC_W], est_q_s};

    // DC tracker accumulators, one per channel; flush does not touch them.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
        end else begin
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
        end
    end
`else
    assign diff_i_s = {x_s[ADC_W], x_s};
    assign diff_q_s = {x_s[ADC_W], x_s};
`endif

    // EOC synchronizer plus a third stage for rise detection; always running.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= eoc;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Pairing FSM next state, the pair to push and DC tracker updates.
    always_comb begin
        state_d    = state_q;
        istore_d   = istore_q;
        pair_i_d   = pair_i_q;
        pair_q_d   = pair_q_q;
        push_req_d = 1'b0;
        err_evt_s  = 1'b0;
`ifdef FM_IQ_DCBLOCK_EN
        acc_i_d    = acc_i_q;
        acc_q_d    = acc_q_q;
`endif
        if (!enable) begin
            state_d = WAIT_I;
        end else if (rise_s) begin
            if (channel == CH_I) begin
                istore_d  = sat_fn(diff_i_s);
                err_evt_s = (state_q == HAVE_I);
                state_d   = HAVE_I;
`ifdef FM_IQ_DCBLOCK_EN
                acc_i_d   = acc_i_q + ACC_W'(diff_i_s);
`endif
            end else if (channel == CH_Q) begin
                if (state_q == HAVE_I) begin
                    pair_i_d   = istore_q;
                    pair_q_d   = sat_fn(diff_q_s);
                    push_req_d = 1'b1;
                    state_d    = WAIT_I;
`ifdef FM_IQ_DCBLOCK_EN
                    acc_q_d    = acc_q_q + ACC_W'(diff_q_s);
`endif
                end else begin
                    err_evt_s = 1'b1;
                end
            end else begin
                state_d = state_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Pairing FSM state and the one-cycle push request register.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= WAIT_I;
            istore_q   <= '0;
            pair_i_q   <= '0;
            pair_q_q   <= '0;
            push_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            istore_q   <= istore_d;
            pair_i_q   <= pair_i_d;
            pair_q_q   <= pair_q_d;
            push_req_q <= push_req_d;
        end
    end

    assign full_s    = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop_s     = iq_valid & iq_ready;
    assign push_ok_s = push_req_q & (~full_s | pop_s);
    assign drop_s    = push_req_q & full_s & ~pop_s;

    // Pair FIFO; a full FIFO with a same-cycle pop reuses the slot being freed.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                fifo_i_q[k] <= '0;
                fifo_q_q[k] <= '0;
            end
        end else if (!enable) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) begin
                fifo_i_q[wr_ptr_q] <= pair_i_q;
                fifo_q_q[wr_ptr_q] <= pair_q_q;
                wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow and saturating counters; clear beats a same-cycle event.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            overflow_q     <= 1'b0;
            drop_cnt_q     <= 8'd0;
            pair_err_cnt_q <= 8'd0;
        end else if (clear) begin
            overflow_q     <= 1'b0;
            drop_cnt_q     <= 8'd0;
            pair_err_cnt_q <= 8'd0;
        end else begin
            overflow_q <= overflow_q | drop_s;
            if (drop_s && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
            if (err_evt_s && (pair_err_cnt_q != 8'hFF)) begin
                pair_err_cnt_q <= pair_err_cnt_q + 8'd1;
            end
        end
    end

    assign iq_valid     = (count_q != '0);
    assign i_data       = fifo_i_q[rd_ptr_q];
    assign q_data       = fifo_q_q[rd_ptr_q];
    assign overflow     = overflow_q;
    assign drop_cnt     = drop_cnt_q;
    assign pair_err_cnt = pair_err_cnt_q;

endmodule

// File: tb/tb_fm_iq_capture.sv
// Directed plus randomized bench for fm_iq_capture with a queue-based model.
module tb_fm_iq_capture;

    localparam int         DEPTH = 4;
    localparam int         SHIFT = 4;
    localparam logic [2:0] CHI   = 3'b110;
    localparam logic [2:0] CHQ   = 3'b100;

    logic        clk = 1'b0;
    logic        RSTn, enable, eoc, iq_ready, clear;
    logic [11:0] adc_data;
    logic [2:0]  channel;
    logic        iq_valid, overflow;
    logic [11:0] i_data, q_data;
    logic [7:0]  drop_cnt, pair_err_cnt;

    int total = 0;
    int bad   = 0;

    // model state
    logic [11:0] mq_i[$];
    logic [11:0] mq_q[$];
    bit          m_pend;
    logic [11:0] m_pend_i;
    int          m_err, m_drop;
    bit          m_ovf;
    longint      m_acc[2];
    logic [11:0] last_i;

    fm_iq_capture #(.ADC_W(12), .FIFO_DEPTH(DEPTH), .DC_SHIFT(SHIFT),
                    .CH_I(CHI), .CH_Q(CHQ)) dut (
        .clk(clk), .RSTn(RSTn), .enable(enable), .eoc(eoc),
        .adc_data(adc_data), .channel(channel), .iq_ready(iq_ready),
        .clear(clear), .iq_valid(iq_valid), .i_data(i_data), .q_data(q_data),
        .overflow(overflow), .drop_cnt(drop_cnt), .pair_err_cnt(pair_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] sat12(input int v);
        int c;
        c = (v > 2047) ? 2047 : ((v < -2048) ? -2048 : v);
        return c[11:0];
    endfunction

    // Signed value of a conversion after optional DC removal on channel ch.
    function automatic logic [11:0] dc_apply(input int ch, input int x);
`ifdef FM_IQ_DCBLOCK_EN
        longint est;
        est = m_acc[ch] >>> SHIFT;
        m_acc[ch] = m_acc[ch] + x - est;
        return sat12(int'(x - est));
`else
        return sat12(x);
`endif
    endfunction

    function automatic void bump_err();
        if (m_err < 255) m_err++;
    endfunction

    function automatic void model_sample(input logic [2:0] ch, input logic [11:0] data);
        int x;
        x = int'(data) - 2048;
        if (ch == CHI) begin
            if (m_pend) bump_err();
            m_pend   = 1'b1;
            m_pend_i = dc_apply(0, x);
        end else if (ch == CHQ) begin
            if (m_pend) begin
                m_pend = 1'b0;
                if (mq_i.size() < DEPTH) begin
                    mq_i.push_back(m_pend_i);
                    mq_q.push_back(dc_apply(1, x));
                end else begin
                    void'(dc_apply(1, x));
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end else begin
                bump_err();
            end
        end
    endfunction

    // One conversion; optionally iq_ready is high for exactly the push cycle.
    task automatic sample(input logic [2:0] ch, input logic [11:0] data, input bit rop);
        @(negedge clk);
        adc_data = data;
        channel  = ch;
        eoc      = 1'b1;
        repeat (3) @(negedge clk);
        if (rop && mq_i.size() > 0) begin
            chk("rop_head_i", {20'd0, i_data}, {20'd0, mq_i[0]});
            chk("rop_head_q", {20'd0, q_data}, {20'd0, mq_q[0]});
            void'(mq_i.pop_front());
            void'(mq_q.pop_front());
        end
        iq_ready = rop;
        eoc      = 1'b0;
        if (enable) model_sample(ch, data);
        @(negedge clk);
        iq_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic drain();
        while (mq_i.size() > 0) begin
            chk("drain_valid", {31'd0, iq_valid}, 32'd1);
            chk("drain_i", {20'd0, i_data}, {20'd0, mq_i[0]});
            chk("drain_q", {20'd0, q_data}, {20'd0, mq_q[0]});
            last_i = i_data;
            void'(mq_i.pop_front());
            void'(mq_q.pop_front());
            iq_ready = 1'b1;
            @(negedge clk);
            iq_ready = 1'b0;
        end
        chk("drain_empty", {31'd0, iq_valid}, 32'd0);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, m_ovf});
        chk({tag, "_drop"}, {24'd0, drop_cnt}, 32'(m_drop));
        chk({tag, "_err"}, {24'd0, pair_err_cnt}, 32'(m_err));
    endtask

    initial begin
        logic [2:0]  rch;
        logic [11:0] rdat;
        int          r;
        RSTn = 1'b0; enable = 1'b0; eoc = 1'b0; iq_ready = 1'b0; clear = 1'b0;
        adc_data = 12'd0; channel = 3'd0;
        m_pend = 1'b0; m_pend_i = 12'd0; m_err = 0; m_drop = 0; m_ovf = 1'b0;
        m_acc[0] = 0; m_acc[1] = 0; last_i = 12'd0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, iq_valid}, 32'd0);
        chk("rst_i", {20'd0, i_data}, 32'd0);
        chk("rst_q", {20'd0, q_data}, 32'd0);
        chk_counters("rst");
        RSTn = 1'b1; enable = 1'b1;
        @(negedge clk);

        // First pair: latency and value check.
        sample(CHI, 12'hA00, 1'b0);
        @(negedge clk);
        adc_data = 12'h600; channel = CHQ; eoc = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("lat_rise", {31'd0, iq_valid}, 32'd0);
        @(negedge clk);
        chk("lat_plus1", {31'd0, iq_valid}, 32'd0);
        eoc = 1'b0;
        model_sample(CHQ, 12'h600);
        @(negedge clk);
        chk("lat_plus2", {31'd0, iq_valid}, 32'd1);
        chk("first_i", {20'd0, i_data}, 32'h200);
        chk("first_q", {20'd0, q_data}, 32'hE00);
        repeat (2) @(negedge clk);
        chk("first_hold_i", {20'd0, i_data}, 32'h200);
        drain();

        // Overflow: five pairs into four entries, then clear.
        for (int n = 0; n < 5; n++) begin
            sample(CHI, 12'($urandom_range(0, 4095)), 1'b0);
            sample(CHQ, 12'($urandom_range(0, 4095)), 1'b0);
        end
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_drop", {24'd0, drop_cnt}, 32'd1);
        chk_counters("ovf");
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_ovf = 1'b0; m_drop = 0; m_err = 0;
        chk_counters("clear");
        drain();

        // Orphan Q, duplicate I.
        sample(CHQ, 12'h123, 1'b0);
        sample(CHI, 12'h456, 1'b0);
        sample(CHI, 12'h789, 1'b0);
        sample(CHQ, 12'hABC, 1'b0);
        chk("dup_err", {24'd0, pair_err_cnt}, 32'd2);
        chk_counters("dup");
        drain();

        // Full FIFO with a pop on the push cycle.
        for (int n = 0; n < 4; n++) begin
            sample(CHI, 12'($urandom_range(0, 4095)), 1'b0);
            sample(CHQ, 12'($urandom_range(0, 4095)), 1'b0);
        end
        sample(CHI, 12'h0F0, 1'b0);
        sample(CHQ, 12'hF0F, 1'b1);
        chk("fullpop_drop", {24'd0, drop_cnt}, 32'd0);
        chk_counters("fullpop");
        drain();

        // Randomized channel/data stream.
        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 3);
            rch = (r == 0 || r == 2) ? CHI : ((r == 1) ? CHQ : 3'b001);
            rdat = 12'($urandom_range(0, 4095));
            sample(rch, rdat, 1'b0);
        end
        chk_counters("rand");
        drain();

`ifdef FM_IQ_DCBLOCK_EN
        for (int n = 0; n < 200; n++) begin
            sample(CHI, 12'h900, 1'b0);
            sample(CHQ, 12'h900, 1'b0);
            drain();
        end
        chk("dc_decay", {31'd0, ($signed(last_i) <= 12'sd1 && $signed(last_i) >= -12'sd1)}, 32'd1);
`endif

        // Disable with two pairs queued, then resume.
        sample(CHI, 12'h321, 1'b0);
        sample(CHQ, 12'h654, 1'b0);
        sample(CHI, 12'h987, 1'b0);
        sample(CHQ, 12'hCBA, 1'b0);
        chk("pre_dis_valid", {31'd0, iq_valid}, 32'd1);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_valid", {31'd0, iq_valid}, 32'd0);
        mq_i.delete(); mq_q.delete(); m_pend = 1'b0;
        sample(CHI, 12'h111, 1'b0);
        sample(CHQ, 12'h222, 1'b0);
        chk("dis_ignored", {31'd0, iq_valid}, 32'd0);
        enable = 1'b1;
        sample(CHI, 12'hB00, 1'b0);
        sample(CHQ, 12'h500, 1'b0);
        chk_counters("reen");
        drain();

        // Asynchronous reset in the middle of a burst.
        sample(CHI, 12'hFFF, 1'b0);
        sample(CHQ, 12'h000, 1'b0);
        sample(CHQ, 12'h000, 1'b0);
        @(negedge clk);
        #2 RSTn = 1'b0;
        #1;
        chk("arst_valid", {31'd0, iq_valid}, 32'd0);
        chk("arst_i", {20'd0, i_data}, 32'd0);
        chk("arst_q", {20'd0, q_data}, 32'd0);
        chk("arst_ovf", {31'd0, overflow}, 32'd0);
        chk("arst_drop", {24'd0, drop_cnt}, 32'd0);
        chk("arst_err", {24'd0, pair_err_cnt}, 32'd0);
        @(negedge clk);
        RSTn = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
